// File: rtl/can_fc_pkg.sv
// rtl/can_fc_pkg.sv - shared types, constants and saturating add for CAN fault confinement
//
// Contents:
//   can_fc_state_t          : 2-bit fault confinement state
//   RECOV_BITS              : recessive bits that make up one recovery occurrence
//   TX_ERR_INC/RX_ERR_INC   : counter steps for transmit / plain receive errors
//   FLAG_ERR_INC            : counter step for dominant-after-flag and 8-dominant events
//   REC_PASSIVE_RELOAD_OFS  : offset below PASSIVE_LIM loaded into rec on rx_ok
//   sat_add()               : unsigned add clamped to a caller-supplied maximum
package can_fc_pkg;

    typedef enum logic [1:0] {
        FC_ACTIVE  = 2'd0,
        FC_PASSIVE = 2'd1,
        FC_BUSOFF  = 2'd2,
        FC_RECOVER = 2'd3
    } can_fc_state_t;

    localparam int RECOV_BITS             = 11;
    localparam int TX_ERR_INC             = 8;
    localparam int RX_ERR_INC             = 1;
    localparam int FLAG_ERR_INC           = 8;
    localparam int REC_PASSIVE_RELOAD_OFS = 9;

    // Operands are zero-extended into 16 bits so one function serves every
    // legal counter width; the extra carry bit makes overflow impossible.
    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [15:0] max_val);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[15:0];
    endfunction

endpackage

// File: rtl/can_fc_recovery_counter.sv
// rtl/can_fc_recovery_counter.sv - bus-off recovery bit and occurrence counters
//
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   enable        : counting allowed (node is in FC_RECOVER)
//   sample_point  : one-cycle bit-sample strobe
//   rx_bit        : sampled bus level, 1 = recessive
//   clear         : synchronous clear of both counters
//   recov_done    : occurrence count has reached RECOV_OCC
module can_fc_recovery_counter
    import can_fc_pkg::*;
#(
    parameter int RECOV_OCC = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic sample_point,
    input  logic rx_bit,
    input  logic clear,
    output logic recov_done
);

    localparam int OCC_W = $clog2(RECOV_OCC + 1);
    localparam logic [3:0]       LAST_BIT = 4'(RECOV_BITS - 1);
    localparam logic [OCC_W-1:0] OCC_DONE = OCC_W'(RECOV_OCC);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    logic [3:0]       bit_cnt;
    logic [OCC_W-1:0] occ_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            occ_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
            occ_cnt <= '0;
        end else if (enable && sample_point) begin
            if (rx_bit) begin
                // The eleventh recessive bit closes an occurrence.
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    if (occ_cnt != OCC_DONE) begin
                        occ_cnt <= occ_cnt + OCC_ONE;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                // A dominant bit restarts the current run; completed
                // occurrences are kept.
                bit_cnt <= '0;
            end
        end
    end

    assign recov_done = (occ_cnt == OCC_DONE);

endmodule

// File: rtl/can_fault_confinement.sv
// rtl/can_fault_confinement.sv - CAN TEC/REC counters and fault confinement state machine
//
// Build option: CAN_FC_AUTO_RECOVERY_EN - when defined, bus-off starts recovery on
// its own the cycle after entry and recov_req is ignored.
//
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   sample_point, rx_bit  : bit-sample strobe and sampled level (recovery counting)
//   err_valid             : error detected, qualified by err_is_tx/err_no_inc/err_bit_flag
//   dom_seq8              : 8 consecutive dominant bits after a flag (err_is_tx selects counter)
//   tx_ok, rx_ok          : successful transmit / receive
//   recov_req             : host request to leave bus-off
//   tec, rec              : transmit / receive error counters
//   fc_state              : current confinement state
//   err_warn              : warning level reached (forced high in bus-off/recovery)
//   state_chg             : one-cycle pulse on every fc_state change
module can_fault_confinement
    import can_fc_pkg::*;
#(
    parameter int CNT_W       = 9,
    parameter int WARN_LIM    = 96,
    parameter int PASSIVE_LIM = 128,
    parameter int BUSOFF_LIM  = 256,
    parameter int RECOV_OCC   = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_point,
    input  logic             rx_bit,
    input  logic             err_valid,
    input  logic             err_is_tx,
    input  logic             err_no_inc,
    input  logic             err_bit_flag,
    input  logic             dom_seq8,
    input  logic             tx_ok,
    input  logic             rx_ok,
    input  logic             recov_req,
    output logic [CNT_W-1:0] tec,
    output logic [CNT_W-1:0] rec,
    output can_fc_state_t    fc_state,
    output logic             err_warn,
    output logic             state_chg
);

    localparam logic [15:0]      CNT_MAX   = 16'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WARN_C    = CNT_W'(WARN_LIM);
    localparam logic [CNT_W-1:0] PASSIVE_C = CNT_W'(PASSIVE_LIM);
    localparam logic [CNT_W-1:0] BUSOFF_C  = CNT_W'(BUSOFF_LIM);
    localparam logic [CNT_W-1:0] RELOAD_C  = CNT_W'(PASSIVE_LIM - REC_PASSIVE_RELOAD_OFS);

    logic [4:0]       tec_inc;
    logic [4:0]       rec_inc;
    logic [CNT_W-1:0] tec_n;
    logic [CNT_W-1:0] rec_n;
    can_fc_state_t    state_n;
    logic             warn_n;
    logic             recov_clr;
    logic             recov_done;

`ifdef CAN_FC_AUTO_RECOVERY_EN
    logic unused_recov_req;
    assign unused_recov_req = recov_req;
`endif

    // Increments from every source in the cycle are summed first so that
    // a simultaneous decrement on the same counter can simply be dropped.
    always_comb begin
        tec_inc = '0;
        rec_inc = '0;
        if (err_valid && !err_no_inc) begin
            if (err_is_tx) begin
                tec_inc = tec_inc + 5'(TX_ERR_INC);
            end else begin
                rec_inc = rec_inc + (err_bit_flag ? 5'(FLAG_ERR_INC) : 5'(RX_ERR_INC));
            end
        end
        if (dom_seq8) begin
            if (err_is_tx) begin
                tec_inc = tec_inc + 5'(FLAG_ERR_INC);
            end else begin
                rec_inc = rec_inc + 5'(FLAG_ERR_INC);
            end
        end
    end

    always_comb begin
        tec_n     = tec;
        rec_n     = rec;
        state_n   = fc_state;
        recov_clr = 1'b0;
        case (fc_state)
            FC_ACTIVE, FC_PASSIVE: begin
                if (tec_inc != '0) begin
                    tec_n = CNT_W'(sat_add(16'(tec), 16'(tec_inc), CNT_MAX));
                end else if (tx_ok && tec != '0) begin
                    tec_n = tec - CNT_ONE;
                end

                if (rec_inc != '0) begin
                    rec_n = CNT_W'(sat_add(16'(rec), 16'(rec_inc), CNT_MAX));
                end else if (rx_ok) begin
                    if (rec > PASSIVE_C) begin
                        rec_n = RELOAD_C;
                    end else if (rec != '0) begin
                        rec_n = rec - CNT_ONE;
                    end
                end

                // Thresholds are judged on the updated counters so the state
                // moves on the same edge as the counter that caused it.
                if (tec_n >= BUSOFF_C) begin
                    state_n = FC_BUSOFF;
                end else if (tec_n >= PASSIVE_C || rec_n >= PASSIVE_C) begin
                    state_n = FC_PASSIVE;
                end else begin
                    state_n = FC_ACTIVE;
                end
            end
            FC_BUSOFF: begin
`ifdef CAN_FC_AUTO_RECOVERY_EN
                state_n = FC_RECOVER;
`else
                if (recov_req) begin
                    state_n = FC_RECOVER;
                end
`endif
            end
            FC_RECOVER: begin
                if (recov_done) begin
                    tec_n     = '0;
                    rec_n     = '0;
                    state_n   = FC_ACTIVE;
                    recov_clr = 1'b1;
                end
            end
            default: state_n = FC_ACTIVE;
        endcase

        warn_n = (state_n == FC_BUSOFF) || (state_n == FC_RECOVER) ||
                 (tec_n >= WARN_C) || (rec_n >= WARN_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tec       <= '0;
            rec       <= '0;
            fc_state  <= FC_ACTIVE;
            err_warn  <= 1'b0;
            state_chg <= 1'b0;
        end else begin
            tec       <= tec_n;
            rec       <= rec_n;
            fc_state  <= state_n;
            err_warn  <= warn_n;
            state_chg <= (state_n != fc_state);
        end
    end

    can_fc_recovery_counter #(
        .RECOV_OCC (RECOV_OCC)
    ) u_recov (
        .clk          (clk),
        .rst          (rst),
        .enable       (fc_state == FC_RECOVER),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .clear        (recov_clr),
        .recov_done   (recov_done)
    );

endmodule

// File: tb/tb_can_fault_confinement.sv
// tb/tb_can_fault_confinement.sv - self-checking bench for can_fault_confinement
module tb_can_fault_confinement;
    import can_fc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sample_point = 1'b0, rx_bit = 1'b1;
    logic err_valid = 1'b0, err_is_tx = 1'b0, err_no_inc = 1'b0, err_bit_flag = 1'b0;
    logic dom_seq8 = 1'b0, tx_ok = 1'b0, rx_ok = 1'b0, recov_req = 1'b0;
    logic [8:0]    tec, rec;
    can_fc_state_t fc_state;
    logic          err_warn, state_chg;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers following the counting rules.
    int            m_tec, m_rec;
    can_fc_state_t m_state;
    logic          m_warn, m_chg;

    always #5 clk = ~clk;

    can_fault_confinement dut (
        .clk(clk), .rst(rst), .sample_point(sample_point), .rx_bit(rx_bit),
        .err_valid(err_valid), .err_is_tx(err_is_tx), .err_no_inc(err_no_inc),
        .err_bit_flag(err_bit_flag), .dom_seq8(dom_seq8), .tx_ok(tx_ok), .rx_ok(rx_ok),
        .recov_req(recov_req), .tec(tec), .rec(rec), .fc_state(fc_state),
        .err_warn(err_warn), .state_chg(state_chg)
    );

    task automatic model_reset();
        m_tec = 0; m_rec = 0; m_state = FC_ACTIVE; m_warn = 1'b0; m_chg = 1'b0;
    endtask

    task automatic model_step();
        can_fc_state_t prev;
        int ti, ri;
        prev = m_state;
        if (m_state == FC_ACTIVE || m_state == FC_PASSIVE) begin
            ti = 0; ri = 0;
            if (err_valid && !err_no_inc) begin
                if (err_is_tx) ti += 8;
                else           ri += err_bit_flag ? 8 : 1;
            end
            if (dom_seq8) begin
                if (err_is_tx) ti += 8;
                else           ri += 8;
            end
            if (ti > 0)                 m_tec = (m_tec + ti > 511) ? 511 : m_tec + ti;
            else if (tx_ok && m_tec > 0) m_tec -= 1;
            if (ri > 0)                 m_rec = (m_rec + ri > 511) ? 511 : m_rec + ri;
            else if (rx_ok && m_rec > 128) m_rec = 119;
            else if (rx_ok && m_rec > 0)   m_rec -= 1;
            if (m_tec >= 256)                    m_state = FC_BUSOFF;
            else if (m_tec >= 128 || m_rec >= 128) m_state = FC_PASSIVE;
            else                                 m_state = FC_ACTIVE;
        end
        m_warn = (m_state == FC_BUSOFF) || (m_state == FC_RECOVER) || m_tec >= 96 || m_rec >= 96;
        m_chg  = (m_state != prev);
    endtask

    task automatic apply(input logic ev, input logic tx, input logic ni, input logic fl,
                         input logic d8, input logic tok, input logic rok);
        err_valid = ev; err_is_tx = tx; err_no_inc = ni; err_bit_flag = fl;
        dom_seq8 = d8; tx_ok = tok; rx_ok = rok;
        model_step();
        @(posedge clk); #1;
        err_valid = 0; err_is_tx = 0; err_no_inc = 0; err_bit_flag = 0;
        dom_seq8 = 0; tx_ok = 0; rx_ok = 0;
    endtask

    task automatic samples(input int n, input logic lvl);
        for (int i = 0; i < n; i++) begin
            sample_point = 1'b1; rx_bit = lvl;
            @(posedge clk); #1;
        end
        sample_point = 1'b0; rx_bit = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) apply(1, 1, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({tec, rec, fc_state, err_warn, state_chg} !== {9'd0, 9'd0, FC_ACTIVE, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_async tec=%0d rec=%0d st=%0d warn=%b chg=%b want 0/0/0/0/0",
                     tec, rec, fc_state, err_warn, state_chg);
        end
        total++;
        if ({dut.u_recov.occ_cnt, dut.u_recov.bit_cnt} !== 12'd0) begin
            bad++;
            $display("FAIL reset_recov occ=%0d bit=%0d want 0/0", dut.u_recov.occ_cnt, dut.u_recov.bit_cnt);
        end
        @(posedge clk); #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_tx_passive();
        int chg_cnt;
        do_reset();
        chg_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            apply(1, 1, 0, 0, 0, 0, 0);
            chg_cnt += int'(state_chg);
        end
        total++;
        if (tec !== 9'd128 || fc_state !== FC_PASSIVE || chg_cnt != 1) begin
            bad++;
            $display("FAIL tx16 tec=%0d st=%0d chg_pulses=%0d want 128/1/1", tec, fc_state, chg_cnt);
        end
        apply(0, 0, 0, 0, 0, 1, 0);
        total++;
        if (tec !== 9'd127 || fc_state !== FC_ACTIVE || state_chg !== 1'b1) begin
            bad++;
            $display("FAIL tx_ok_back tec=%0d st=%0d chg=%b want 127/0/1", tec, fc_state, state_chg);
        end
    endtask

    task automatic test_busoff_freeze();
        do_reset();
        for (int i = 0; i < 32; i++) apply(1, 1, 0, 0, 0, 0, 0);
        total++;
        if (tec !== 9'd256 || fc_state !== FC_BUSOFF || err_warn !== 1'b1) begin
            bad++;
            $display("FAIL busoff_entry tec=%0d st=%0d warn=%b want 256/2/1", tec, fc_state, err_warn);
        end
        apply(1, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 1);
        apply(1, 0, 0, 1, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 1, 0);
        total++;
        if (tec !== 9'd256 || rec !== 9'd0 || err_warn !== 1'b1) begin
            bad++;
            $display("FAIL busoff_frozen tec=%0d rec=%0d warn=%b want 256/0/1", tec, rec, err_warn);
        end
    endtask

    // Entered with the DUT in bus-off.
    task automatic test_recovery();
`ifdef CAN_FC_AUTO_RECOVERY_EN
        @(posedge clk); #1;
        total++;
        if (fc_state !== FC_RECOVER) begin
            bad++;
            $display("FAIL auto_enter st=%0d want 3", fc_state);
        end
`else
        samples(2000, 1'b1);
        total++;
        if (fc_state !== FC_BUSOFF || tec !== 9'd256) begin
            bad++;
            $display("FAIL wait_req st=%0d tec=%0d want 2/256", fc_state, tec);
        end
        recov_req = 1'b1; @(posedge clk); #1 recov_req = 1'b0;
        total++;
        if (fc_state !== FC_RECOVER || state_chg !== 1'b1) begin
            bad++;
            $display("FAIL req_enter st=%0d chg=%b want 3/1", fc_state, state_chg);
        end
`endif
        samples(49 * 11 + 10, 1'b1);
        samples(1, 1'b0);
        total++;
        if (dut.u_recov.occ_cnt !== 8'd49 || dut.u_recov.bit_cnt !== 4'd0) begin
            bad++;
            $display("FAIL dominant_bit10 occ=%0d bit=%0d want 49/0", dut.u_recov.occ_cnt, dut.u_recov.bit_cnt);
        end
`ifdef CAN_FC_AUTO_RECOVERY_EN
        samples(79 * 11 - 1, 1'b1);
`else
        do_reset();
        total++;
        if (dut.u_recov.occ_cnt !== 8'd0 || fc_state !== FC_ACTIVE || tec !== 9'd0) begin
            bad++;
            $display("FAIL reset_mid_recov occ=%0d st=%0d tec=%0d want 0/0/0", dut.u_recov.occ_cnt, fc_state, tec);
        end
        for (int i = 0; i < 32; i++) apply(1, 1, 0, 0, 0, 0, 0);
        recov_req = 1'b1; @(posedge clk); #1 recov_req = 1'b0;
        samples(1407, 1'b1);
`endif
        total++;
        if (fc_state !== FC_RECOVER || tec !== 9'd256) begin
            bad++;
            $display("FAIL recov_one_short st=%0d tec=%0d want 3/256", fc_state, tec);
        end
        samples(1, 1'b1);
        for (int i = 0; i < 4 && fc_state !== FC_ACTIVE; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (fc_state !== FC_ACTIVE || tec !== 9'd0 || rec !== 9'd0 || err_warn !== 1'b0) begin
            bad++;
            $display("FAIL recov_done st=%0d tec=%0d rec=%0d warn=%b want 0/0/0/0", fc_state, tec, rec, err_warn);
        end
        model_reset();
        recov_req = 1'b1; @(posedge clk); #1 recov_req = 1'b0;
        total++;
        if (fc_state !== FC_ACTIVE || state_chg !== 1'b0) begin
            bad++;
            $display("FAIL req_in_active st=%0d chg=%b want 0/0", fc_state, state_chg);
        end
    endtask

    task automatic test_rec_reload();
        do_reset();
        for (int i = 0; i < 16; i++) apply(1, 0, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (rec !== 9'd130 || fc_state !== FC_PASSIVE) begin
            bad++;
            $display("FAIL rec130 rec=%0d st=%0d want 130/1", rec, fc_state);
        end
        apply(0, 0, 0, 0, 0, 0, 1);
        total++;
        if (rec !== 9'd119 || fc_state !== FC_ACTIVE) begin
            bad++;
            $display("FAIL rec_reload rec=%0d st=%0d want 119/0", rec, fc_state);
        end
        apply(1, 0, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 1);
        total++;
        if (rec !== 9'd127 || fc_state !== FC_ACTIVE) begin
            bad++;
            $display("FAIL rec128_dec rec=%0d st=%0d want 127/0", rec, fc_state);
        end
        do_reset();
        apply(0, 0, 0, 0, 0, 0, 1);
        total++;
        if (rec !== 9'd0) begin
            bad++;
            $display("FAIL rec0_rx_ok rec=%0d want 0", rec);
        end
    endtask

    task automatic test_concurrent();
        do_reset();
        apply(1, 1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) apply(0, 0, 0, 0, 0, 1, 0);
        apply(1, 1, 0, 0, 0, 1, 0);
        total++;
        if (tec !== 9'd18) begin
            bad++;
            $display("FAIL inc_beats_dec tec=%0d want 18", tec);
        end
        apply(1, 1, 1, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 0, 0);
        total++;
        if (tec !== 9'd18 || rec !== 9'd0) begin
            bad++;
            $display("FAIL no_inc tec=%0d rec=%0d want 18/0", tec, rec);
        end
        apply(1, 0, 0, 1, 1, 0, 1);
        apply(1, 1, 0, 0, 1, 0, 0);
        total++;
        if (rec !== 9'd16 || tec !== 9'd34) begin
            bad++;
            $display("FAIL sum_sources rec=%0d tec=%0d want 16/34", rec, tec);
        end
        do_reset();
        for (int i = 0; i < 63; i++) apply(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0, 0);
        total++;
        if (rec !== 9'd511 || fc_state !== FC_PASSIVE) begin
            bad++;
            $display("FAIL rec_sat rec=%0d st=%0d want 511/1", rec, fc_state);
        end
        apply(1, 0, 0, 1, 1, 0, 0);
        total++;
        if (rec !== 9'd511) begin
            bad++;
            $display("FAIL rec_sat_hold rec=%0d want 511", rec);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            apply($urandom_range(3) == 0, $urandom_range(1) == 0, $urandom_range(7) == 0,
                  $urandom_range(1) == 0, $urandom_range(15) == 0,
                  $urandom_range(2) != 0, $urandom_range(3) == 0);
            total++;
            if (tec !== 9'(m_tec) || rec !== 9'(m_rec) || fc_state !== m_state ||
                err_warn !== m_warn || state_chg !== m_chg) begin
                bad++;
                $display("FAIL random[%0d] tec=%0d/%0d rec=%0d/%0d st=%0d/%0d warn=%b/%b chg=%b/%b (got/want)",
                         n, tec, m_tec, rec, m_rec, fc_state, m_state, err_warn, m_warn, state_chg, m_chg);
            end
            if (m_state == FC_BUSOFF) do_reset();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tx_passive();
        test_busoff_freeze();
        test_recovery();
        test_rec_reload();
        test_concurrent();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
